// File: rtl/puf_response_collector.sv
// Datapath for ring-oscillator PUF evaluation: synchronizes the selected RO pair,
// counts edges, majority-votes per-loop comparison bits and publishes the response.
module puf_response_collector #(
  parameter int NUM_LOOPS        = 4,
  parameter int COUNT_BITS       = 16,
  parameter int REPETITIONS_BITS = 16,
  localparam int SEL_W           = $clog2(NUM_LOOPS-1)+1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   done,
  input  logic                   reset_puf,
  input  logic [SEL_W-1:0]       select_puf,
  input  logic                   enable_puf,
  input  logic                   store_response_puf,
  input  logic [2*NUM_LOOPS-1:0] ro_out,
  output logic                   next_enable,
  output logic [NUM_LOOPS-1:0]   response,
  output logic                   response_valid,
  output logic                   overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, VALID} state_t;

  state_t                  state_reg, state_next;
  logic                    done_d_reg;
  logic [2:0]              sync_a_reg, sync_b_reg;
  logic [COUNT_BITS-1:0]   count_a_reg, count_b_reg;
  logic                    next_enable_reg;
  logic [NUM_LOOPS-1:0]    response_reg;
  logic                    response_valid_reg;
  logic                    overflow_reg;

  logic                    ro_a, ro_b;
  logic                    sel_valid;
  logic                    done_rise;
  logic                    in_accum;
  logic                    rise_a, rise_b;
  logic                    inc_a, inc_b;
  logic                    clr_counts;
  logic                    ovf_a, ovf_b;
  logic                    store_ok;
  logic                    cmp_bit;
  logic [NUM_LOOPS-1:0]    vote_ovf;
  logic [NUM_LOOPS-1:0]    resp_bits;

  assign sel_valid = ({1'b0, select_puf} < (SEL_W+1)'(NUM_LOOPS));
  assign done_rise = done & ~done_d_reg;
  assign in_accum  = (state_reg == ACCUM);

  // Out-of-range selects feed constant 0 so nothing is counted.
  always_comb begin
    ro_a = 1'b0;
    ro_b = 1'b0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (select_puf == SEL_W'(i)) begin
        ro_a = ro_out[2*i];
        ro_b = ro_out[2*i+1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      done_d_reg <= 1'b0;
      sync_a_reg <= '0;
      sync_b_reg <= '0;
    end else begin
      state_reg  <= state_next;
      done_d_reg <= done;
      sync_a_reg <= {sync_a_reg[1:0], ro_a};
      sync_b_reg <= {sync_b_reg[1:0], ro_b};
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM:   if (start) state_next = ACCUM;
               else if (done_rise) state_next = VALID;
      VALID:   if (start) state_next = ACCUM;
      default: state_next = IDLE;
    endcase
  end

  assign rise_a     = sync_a_reg[1] & ~sync_a_reg[2];
  assign rise_b     = sync_b_reg[1] & ~sync_b_reg[2];
  assign clr_counts = start | reset_puf;
  assign inc_a      = in_accum & enable_puf & sel_valid & rise_a;
  assign inc_b      = in_accum & enable_puf & sel_valid & rise_b;
  // Overflow flags an edge lost because the counter is already pinned at all-ones.
  assign ovf_a      = inc_a & (&count_a_reg) & ~clr_counts;
  assign ovf_b      = inc_b & (&count_b_reg) & ~clr_counts;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_a_reg <= '0;
      count_b_reg <= '0;
    end else if (clr_counts) begin
      count_a_reg <= '0;
      count_b_reg <= '0;
    end else begin
      if (inc_a && !(&count_a_reg)) count_a_reg <= count_a_reg + 1'b1;
      if (inc_b && !(&count_b_reg)) count_b_reg <= count_b_reg + 1'b1;
    end
  end

  // Store reads the counts as registered, so a same-cycle reset_puf cannot disturb it.
  assign store_ok = in_accum & store_response_puf & sel_valid & ~start;
  assign cmp_bit  = (count_a_reg > count_b_reg);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LOOPS; gi++) begin : g_loop
      logic [REPETITIONS_BITS-1:0] votes_reg, reps_reg;
      logic                        hit;

      assign hit = store_ok && (select_puf == SEL_W'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          votes_reg <= '0;
          reps_reg  <= '0;
        end else if (start) begin
          votes_reg <= '0;
          reps_reg  <= '0;
        end else if (hit) begin
          if (!(&reps_reg)) reps_reg <= reps_reg + 1'b1;
          if (cmp_bit && !(&votes_reg)) votes_reg <= votes_reg + 1'b1;
        end
      end

      assign vote_ovf[gi]  = hit & ((&reps_reg) | (cmp_bit & (&votes_reg)));
      assign resp_bits[gi] = ({votes_reg, 1'b0} > {1'b0, reps_reg});
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      next_enable_reg    <= 1'b0;
      response_reg       <= '0;
      response_valid_reg <= 1'b0;
      overflow_reg       <= 1'b0;
    end else begin
      next_enable_reg <= store_response_puf & in_accum;
      if (start) begin
        response_reg       <= '0;
        response_valid_reg <= 1'b0;
        overflow_reg       <= 1'b0;
      end else begin
        if (in_accum && done_rise) begin
          response_reg       <= resp_bits;
          response_valid_reg <= 1'b1;
        end
        if (ovf_a || ovf_b || (|vote_ovf)) overflow_reg <= 1'b1;
      end
    end
  end

  assign next_enable    = next_enable_reg;
  assign response       = response_reg;
  assign response_valid = response_valid_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_puf_response_collector.sv
// Directed bench for puf_response_collector: a default instance plus a 4-bit-counter
// instance sharing the same stimulus for the saturation case.
module tb_puf_response_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic       reset_puf = 1'b0;
  logic [2:0] select_puf = '0;
  logic       enable_puf = 1'b0;
  logic       store_response_puf = 1'b0;
  logic [7:0] ro_out = '0;

  logic       next_enable, response_valid, overflow;
  logic [3:0] response;
  logic       sat_next_enable, sat_response_valid, sat_overflow;
  logic [3:0] sat_response;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  puf_response_collector dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .reset_puf(reset_puf),
    .select_puf(select_puf), .enable_puf(enable_puf),
    .store_response_puf(store_response_puf), .ro_out(ro_out),
    .next_enable(next_enable), .response(response),
    .response_valid(response_valid), .overflow(overflow)
  );

  puf_response_collector #(.COUNT_BITS(4)) sat (
    .clk(clk), .reset(reset), .start(start), .done(done), .reset_puf(reset_puf),
    .select_puf(select_puf), .enable_puf(enable_puf),
    .store_response_puf(store_response_puf), .ro_out(ro_out),
    .next_enable(sat_next_enable), .response(sat_response),
    .response_valid(sat_response_valid), .overflow(sat_overflow)
  );

  typedef struct {
    int sel;
    int na;
    int nb;
    int exp_ca;
    int exp_cb;
    int exp_next;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_reset_puf();
    reset_puf = 1'b1; tick(); reset_puf = 1'b0;
  endtask

  task automatic pulse_store();
    store_response_puf = 1'b1; tick(); store_response_puf = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1; tick(); done = 1'b0;
  endtask

  // na rising edges on A and nb on B of the selected loop, 4-cycle period, then drain.
  task automatic window(input int sel, input int na, input int nb);
    int n;
    n = (na > nb) ? na : nb;
    enable_puf = 1'b1;
    for (int k = 0; k < n; k++) begin
      if (sel < 4) begin
        ro_out[2*sel]   = (k < na);
        ro_out[2*sel+1] = (k < nb);
      end
      tick(); tick();
      ro_out = '0;
      tick(); tick();
    end
    tick(); tick(); tick();
    enable_puf = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1, 3, 1, 3, 1, 1};
    tbl[1] = '{1, 1, 3, 1, 3, 1};
    tbl[2] = '{1, 5, 2, 5, 2, 1};
    tbl[3] = '{2, 4, 2, 4, 2, 1};
    tbl[4] = '{2, 2, 2, 2, 2, 1};
    tbl[5] = '{3, 3, 3, 3, 3, 1};
    tbl[6] = '{5, 3, 0, 0, 0, 1};

    // Reset held with oscillators toggling
    for (int k = 0; k < 10; k++) begin
      ro_out = ~ro_out;
      tick();
    end
    check("rst_response", response, 0);
    check("rst_valid", response_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_next_enable", next_enable, 0);
    check("rst_count_a", dut.count_a_reg, 0);
    ro_out = '0;
    #2 reset = 1'b1;
    tick(); tick(); tick();
    pulse_store();
    check("idle_store_next_enable", next_enable, 0);
    check("idle_store_reps", dut.g_loop[0].reps_reg, 0);

    // Single loop: A every 2 cycles, B every 4 cycles over 40 cycles
    pulse_start();
    select_puf = 3'd0;
    pulse_reset_puf();
    tick(); tick(); tick();
    enable_puf = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k % 2 == 0) ro_out[0] = ~ro_out[0];
      if (k % 4 == 0) ro_out[1] = ~ro_out[1];
    end
    tick(); tick(); tick();
    enable_puf = 1'b0;
    check("single_count_a", dut.count_a_reg, 10);
    check("single_count_b", dut.count_b_reg, 5);
    pulse_store();
    check("single_next_enable", next_enable, 1);
    tick();
    check("single_next_enable_drop", next_enable, 0);

    // Majority table
    for (int i = 0; i < 7; i++) begin
      select_puf = 3'(tbl[i].sel);
      pulse_reset_puf();
      tick(); tick(); tick();
      window(tbl[i].sel, tbl[i].na, tbl[i].nb);
      check($sformatf("vec%0d_count_a", i), dut.count_a_reg, tbl[i].exp_ca);
      check($sformatf("vec%0d_count_b", i), dut.count_b_reg, tbl[i].exp_cb);
      pulse_store();
      check($sformatf("vec%0d_next_enable", i), next_enable, tbl[i].exp_next);
    end
    check("pre_done_valid", response_valid, 0);
    pulse_done();
    check("majority_response", response, 4'b0011);
    check("majority_valid", response_valid, 1);
    tick(); tick();
    check("majority_valid_hold", response_valid, 1);
    pulse_store();
    check("valid_store_ignored", next_enable, 0);

    // Store and reset_puf in the same cycle
    pulse_start();
    check("start_clears_valid", response_valid, 0);
    check("start_clears_response", response, 0);
    select_puf = 3'd0;
    pulse_reset_puf();
    tick(); tick(); tick();
    window(0, 2, 1);
    store_response_puf = 1'b1;
    reset_puf = 1'b1;
    tick();
    store_response_puf = 1'b0;
    reset_puf = 1'b0;
    check("collide_count_a", dut.count_a_reg, 0);
    check("collide_next_enable", next_enable, 1);
    pulse_done();
    check("collide_response", response, 4'b0001);

    // start and done together: start wins
    start = 1'b1;
    done = 1'b1;
    tick();
    start = 1'b0;
    done = 1'b0;
    check("start_done_valid", response_valid, 0);
    check("start_done_response", response, 0);
    pulse_store();
    check("start_done_in_accum", next_enable, 1);

    // Saturation on the 4-bit instance
    pulse_start();
    select_puf = 3'd0;
    pulse_reset_puf();
    tick(); tick(); tick();
    window(0, 20, 0);
    check("sat_count_a", sat.count_a_reg, 15);
    check("sat_overflow", sat_overflow, 1);
    check("wide_count_a", dut.count_a_reg, 20);
    check("wide_overflow", overflow, 0);
    pulse_start();
    check("sat_overflow_cleared", sat_overflow, 0);

    // Async reset mid-ACCUM after two stores
    pulse_reset_puf();
    tick(); tick(); tick();
    window(0, 20, 0);
    pulse_store();
    select_puf = 3'd1;
    pulse_store();
    check("pre_areset_next_enable", next_enable, 1);
    check("pre_areset_overflow", sat_overflow, 1);
    check("pre_areset_reps1", dut.g_loop[1].reps_reg, 1);
    #2 reset = 1'b0;
    #1;
    check("areset_next_enable", next_enable, 0);
    check("areset_overflow", sat_overflow, 0);
    check("areset_reps0", dut.g_loop[0].reps_reg, 0);
    check("areset_count_a", dut.count_a_reg, 0);
    #1 reset = 1'b1;
    tick();
    pulse_done();
    check("done_after_areset_valid", response_valid, 0);
    check("done_after_areset_response", response, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puf_response_collector.md
# puf_response_collector

Datapath counterpart of the PUF `StateMachine` controller.
- Consumes the controller's `reset_puf` / `select_puf` / `enable_puf` / `store_response_puf` strobes.
- Counts edges of the selected ring-oscillator pair and compares the two counts on each store.
- Majority-votes the per-loop comparison bits across repetitions.
- Returns `next_enable` to the controller and publishes the final `NUM_LOOPS`-bit response once the controller signals `done`.

## Interface
- `NUM_LOOPS`, 4: number of oscillator pairs (loops); one response bit per loop.
- `COUNT_BITS`, 16: width of each edge counter.
- `REPETITIONS_BITS`, 16: width of per-loop vote and repetition counters.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse from top level: clear accumulators, begin a new challenge.
- `done`  in  1  from controller: evaluation finished, latch response.
- `reset_puf`  in  1  clear both edge counters.
- `select_puf`  in  $clog2(NUM_LOOPS-1)+1  loop index being evaluated.
- `enable_puf`  in  1  counting window.
- `store_response_puf`  in  1  one-cycle pulse: compare counts, record vote.
- `ro_out`  in  2*NUM_LOOPS  asynchronous oscillator outputs; loop i = A at bit 2i, B at bit 2i+1.
- `next_enable`  out  1  one-cycle pulse: store committed, controller may advance.
- `response`  out  NUM_LOOPS  voted response.
- `response_valid`  out  1  `response` is final.
- `overflow`  out  1  sticky: an edge or repetition counter saturated.

## Operation
- States:
  - IDLE: entered from reset. `start` → ACCUM.
  - ACCUM: `done` rising edge → VALID; `start` restarts ACCUM.
  - VALID: `start` → ACCUM.
- On `start` (any state): clear votes, repetition counts, edge counters, `response`, `response_valid`, `overflow`.
- Synchronizer: the selected A and B lines pass through a 2-flop synchronizer plus a 3rd flop. A rising edge is `sync2 & ~sync3`.
- Edge counting: `count_a` / `count_b` increment on a detected edge while `enable_puf`=1 and state=ACCUM.
  - Counters saturate at all-ones; saturation sets `overflow`.
  - `reset_puf` clears both counters. Clear wins over a same-cycle increment.
- Store (ACCUM only):
  - bit = (`count_a` > `count_b`); a tie gives 0.
  - `reps[select_puf]` += 1; `votes[select_puf]` += bit. Both saturate and set `overflow`.
  - A store uses the counts registered before any same-cycle `reset_puf` clear.
  - Stores in IDLE or VALID are ignored: no counter update, no `next_enable`.
- `select_puf` ≥ `NUM_LOOPS`: counting is disabled and stores are ignored, but `next_enable` still pulses so the controller never stalls.
- Finalize: on the `done` rising edge in ACCUM, `response[i]` = (2·`votes[i]` > `reps[i]`), computed at width `REPETITIONS_BITS`+1.
  - A loop with zero repetitions gives 0.
- Simultaneous `start` and `done`: `start` wins; state stays ACCUM with cleared accumulators.

## Timing
- Reset values: `next_enable`=0, `response`=0, `response_valid`=0, `overflow`=0, state IDLE, all counters 0.
- Edge latency: an `ro_out` transition is counted 3 `clk` edges later, if `enable_puf` is high in the detection cycle. Edges must be spaced ≥2 `clk` cycles apart to be counted individually.
- `next_enable` is a registered pulse, high exactly in the cycle after `store_response_puf`.
- `response` and `response_valid` update in the cycle after the `done` rising edge. `response_valid` holds until `start` or `reset`.
- Changing `select_puf` mid-window is legal. The synchronizer is not flushed, so the first 2 cycles after a change may count a spurious edge. The controller issues `reset_puf` after every select change.
- Asynchronous reset mid-operation: all state drops to reset values immediately. Recovery is synchronous on the deasserting edge.

## Test plan
- Reset: hold `reset`=0 for 10 cycles with `ro_out` toggling → all outputs 0, state IDLE; `store_response_puf` pulse gives no `next_enable`.
- Single loop: `start`, select 0, `reset_puf`. Toggle A every 2 cycles and B every 4 cycles during a 40-cycle `enable_puf` window → `count_a`≈10, `count_b`≈5. Store → `next_enable` pulse in the following cycle. `done` → `response[0]`=1, `response_valid`=1.
- Majority: loop 1 with 3 repetitions producing bits 1,0,1 → `response[1]`=1. Loop 2 with bits 1,0 (tie 1 of 2) → `response[2]`=0. Equal counts → bit 0.
- Collisions: `store_response_puf`+`reset_puf` same cycle → vote uses old counts, counters read 0 next cycle. `start`+`done` same cycle → `response_valid` stays 0.
- Saturation: `COUNT_BITS`=4, 20 A edges in one window → `count_a`=15, `overflow`=1. `overflow` clears on `start`.
- Async reset mid-ACCUM after 2 stores → outputs 0 immediately. A subsequent `done` without `start` leaves `response_valid`=0.
